// File: rtl/psum_acc_buf_pkg.sv
// Shared constants and state encoding for the partial-sum accumulation buffer.
package psum_acc_buf_pkg;

  localparam int DEF_TILE_LEN = 28;
  localparam int DEF_PSUM_W   = 16;
  localparam int DEF_ACC_W    = 24;
  localparam int OUT_W        = 8;
  localparam int PTR_W        = 5;
  localparam int SHIFT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/psum_acc_buf_requant_relu.sv
// Combinational ReLU, arithmetic right shift and clamp of an accumulator
// entry down to an unsigned output pixel.
module requant_relu
  import psum_acc_buf_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   pix_o
);

  logic [ACC_W-1:0] mag_s;
  logic [ACC_W-1:0] shifted_s;

  // Negative sums clip to zero; anything above the output range saturates.
  always_comb begin
    mag_s     = {ACC_W{1'b0}};
    shifted_s = {ACC_W{1'b0}};
    pix_o     = {OUT_W{1'b0}};
    if (acc_i[ACC_W-1]) begin
      mag_s = {ACC_W{1'b0}};
    end else begin
      mag_s = acc_i;
    end
    shifted_s = mag_s >> shift_i;
    if (|shifted_s[ACC_W-1:OUT_W]) begin
      pix_o = {OUT_W{1'b1}};
    end else begin
      pix_o = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_acc_buf.sv
// Accumulates partial sums across input channels into a tile-sized buffer and
// emits requantized pixels one cycle after each last-channel beat.
module psum_acc_buf
  import psum_acc_buf_pkg::*;
#(
  parameter int TILE_LEN = DEF_TILE_LEN,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_conv,
  input  logic              p_valid_i,
  input  logic              last_chanel_i,
  input  logic              end_conv_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic [3:0]        cfg_shift,
  output logic              ofm_valid,
  output logic [7:0]        ofm_data,
  output logic [4:0]        ofm_addr,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               first_q, first_d;
  logic               ovf_q, ovf_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               ofm_valid_q, ofm_valid_d;
  logic [OUT_W-1:0]   ofm_data_q, ofm_data_d;
  logic [PTR_W-1:0]   ofm_addr_q, ofm_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   mem_q [TILE_LEN];

  logic               beat_s;
  logic               wrap_s;
  logic [ACC_W:0]     rd_ext_s;
  logic [ACC_W:0]     ps_ext_s;
  logic [ACC_W:0]     sum_s;
  logic               sat_s;
  logic [ACC_W-1:0]   acc_s;
  logic [OUT_W-1:0]   pix_s;

  // A restart in the same cycle as a beat wins; the beat is dropped.
  assign beat_s = (state_q == ST_RUN) && p_valid_i && !start_conv;
  assign wrap_s = (ptr_q == PTR_W'(TILE_LEN - 1));

  // Widened add with signed saturation back to the accumulator width.
  always_comb begin
    rd_ext_s = {mem_q[ptr_q][ACC_W-1], mem_q[ptr_q]};
    ps_ext_s = {{(ACC_W + 1 - PSUM_W){psum_i[PSUM_W-1]}}, psum_i};
    if (first_q) begin
      sum_s = ps_ext_s;
    end else begin
      sum_s = rd_ext_s + ps_ext_s;
    end
    sat_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (!sat_s) begin
      acc_s = sum_s[ACC_W-1:0];
    end else if (sum_s[ACC_W]) begin
      acc_s = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      acc_s = {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  requant_relu #(
    .ACC_W(ACC_W)
  ) u_requant (
    .acc_i  (acc_s),
    .shift_i(shift_q),
    .pix_o  (pix_s)
  );

  // Buffer entries are never reset: the first channel of a group overwrites them.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      mem_q[ptr_q] <= acc_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_conv) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start_conv)      state_d = ST_RUN;
        else if (end_conv_i) state_d = ST_DONE;
        else                 state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_conv) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, registered so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Pointer, channel tracking, sticky overflow and output pixel staging.
  always_comb begin
    ptr_d       = ptr_q;
    first_d     = first_q;
    ovf_d       = ovf_q;
    shift_d     = shift_q;
    ofm_valid_d = 1'b0;
    ofm_data_d  = ofm_data_q;
    ofm_addr_d  = ofm_addr_q;
    if (start_conv) begin
      ptr_d   = {PTR_W{1'b0}};
      first_d = 1'b1;
      ovf_d   = 1'b0;
      shift_d = cfg_shift;
    end else if (beat_s) begin
      if (wrap_s) begin
        ptr_d   = {PTR_W{1'b0}};
        first_d = last_chanel_i;
      end else begin
        ptr_d   = ptr_q + 5'd1;
        first_d = first_q;
      end
      if (sat_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (last_chanel_i) begin
        ofm_valid_d = 1'b1;
        ofm_data_d  = pix_s;
        ofm_addr_d  = ptr_q;
      end else begin
        ofm_valid_d = 1'b0;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {PTR_W{1'b0}};
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      shift_q     <= {SHIFT_W{1'b0}};
      ofm_valid_q <= 1'b0;
      ofm_data_q  <= {OUT_W{1'b0}};
      ofm_addr_q  <= {PTR_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      shift_q     <= shift_d;
      ofm_valid_q <= ofm_valid_d;
      ofm_data_q  <= ofm_data_d;
      ofm_addr_q  <= ofm_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ofm_valid = ofm_valid_q;
  assign ofm_data  = ofm_data_q;
  assign ofm_addr  = ofm_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed bench for psum_acc_buf: stimulus pushes expected pixels into a
// queue, an independent monitor pops and compares on every ofm_valid.
module tb_psum_acc_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_conv = 1'b0;
  logic        p_valid_i = 1'b0;
  logic        last_chanel_i = 1'b0;
  logic        end_conv_i = 1'b0;
  logic [15:0] psum_i = 16'd0;
  logic [3:0]  cfg_shift = 4'd0;
  logic        ofm_valid;
  logic [7:0]  ofm_data;
  logic [4:0]  ofm_addr;
  logic        busy;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  psum_acc_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_conv   (start_conv),
    .p_valid_i    (p_valid_i),
    .last_chanel_i(last_chanel_i),
    .end_conv_i   (end_conv_i),
    .psum_i       (psum_i),
    .cfg_shift    (cfg_shift),
    .ofm_valid    (ofm_valid),
    .ofm_data     (ofm_data),
    .ofm_addr     (ofm_addr),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every presented pixel must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ofm_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ofm: addr=%0d data=%0d, expected no output", ofm_addr, ofm_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("ofm_addr", int'(ofm_addr), int'(mon_e.addr));
        check("ofm_data", int'(ofm_data), int'(mon_e.data));
      end
    end
  end

  task automatic start(input logic [3:0] sh);
    start_conv = 1'b1;
    cfg_shift  = sh;
    @(posedge clk);
    #1;
    start_conv = 1'b0;
  endtask

  task automatic beat(input int ps, input logic last, input logic push,
                      input int ex_addr, input int ex_data, input logic endc);
    exp_t e;
    p_valid_i     = 1'b1;
    psum_i        = ps[15:0];
    last_chanel_i = last;
    end_conv_i    = endc;
    if (push) begin
      e.addr = ex_addr[4:0];
      e.data = ex_data[7:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    p_valid_i     = 1'b0;
    last_chanel_i = 1'b0;
    end_conv_i    = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ofm_valid", int'(ofm_valid), 0);
    check("rst_ofm_data",  int'(ofm_data), 0);
    check("rst_ofm_addr",  int'(ofm_addr), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_ovf",       int'(ovf), 0);
    rst_n = 1'b1;

    // Beats in IDLE must be ignored and must not move the pointer.
    beat(9, 1'b1, 1'b0, 0, 0, 1'b0);
    beat(9, 1'b1, 1'b0, 0, 0, 1'b0);
    check("idle_busy", int'(busy), 0);

    // Single channel, identity requantization.
    start(4'd0);
    check("run_busy", int'(busy), 1);
    for (int i = 0; i < 28; i++) beat(i, 1'b1, 1'b1, i, i, 1'b0);
    drain("single_drained");

    // Three channels of 5: outputs only on the third group.
    start(4'd0);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 28; i++)
        beat(5, g == 2, g == 2, i, 15, 1'b0);
    drain("three_ch_drained");

    // ReLU and clamp with shift 2: -7 -> 0, 1000 -> 250, 2000 -> 255, 8 -> 2.
    start(4'd2);
    for (int i = 0; i < 28; i++)
      beat((i == 0) ? -3 : (i == 1) ? 500 : (i == 2) ? 1000 : 4, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 28; i++)
      beat((i == 0) ? -4 : (i == 1) ? 500 : (i == 2) ? 1000 : 4, 1'b1, 1'b1, i,
           (i == 0) ? 0 : (i == 1) ? 250 : (i == 2) ? 255 : 2, 1'b0);
    drain("relu_drained");
    check("relu_ovf", int'(ovf), 0);

    // Saturation: 256*32767 fits, the 257th channel pins at 8388607.
    start(4'd15);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 28; i++) begin
        beat(32767, c == 299, c == 299, i, 255, 1'b0);
        if (c == 255 && i == 27) check("ovf_before_sat", int'(ovf), 0);
        if (c == 256 && i == 0)  check("ovf_at_sat", int'(ovf), 1);
      end
    end
    drain("sat_drained");
    end_conv_i = 1'b1;
    @(posedge clk);
    #1;
    end_conv_i = 1'b0;
    check("sat_done", int'(done), 1);
    check("sat_ovf_done", int'(ovf), 1);
    @(posedge clk);
    #1;
    check("sat_ovf_idle", int'(ovf), 1);
    check("sat_done_idle", int'(done), 0);

    // end_conv coincident with the final beat.
    start(4'd0);
    check("restart_ovf_clr", int'(ovf), 0);
    for (int i = 0; i < 28; i++) begin
      beat(2 * i, 1'b1, 1'b1, i, 2 * i, i == 27);
      if (i == 26) check("end_busy_run", int'(busy), 1);
    end
    check("end_done", int'(done), 1);
    check("end_busy_done", int'(busy), 0);
    @(posedge clk);
    #1;
    check("end_done_pulse", int'(done), 0);
    check("end_busy_idle", int'(busy), 0);
    drain("end_drained");

    // Reset mid-group while an output pixel is being presented.
    start(4'd0);
    for (int i = 0; i < 28; i++) beat(50, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) beat(7, 1'b1, 1'b1, i, 57, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ofm_valid", int'(ofm_valid), 0);
    check("midrst_ofm_data",  int'(ofm_data), 0);
    check("midrst_ofm_addr",  int'(ofm_addr), 0);
    check("midrst_busy",      int'(busy), 0);
    check("midrst_pending",   exp_q.size(), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(4'd0);
    for (int i = 0; i < 28; i++) beat(3, 1'b1, 1'b1, i, 3, 1'b0);
    drain("post_rst_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
